// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// SEQ stage-controller state encoding.
package y86_pkg;

  // Instruction codes (icode field of the first instruction byte)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Processor status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Sequencer states, one per SEQ stage plus idle and halted
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_PCUPDATE,
    ST_HALTED
  } ctrl_state_t;

endpackage

// File: rtl/seq_icode_class.sv
// Combinational icode classifier: which optional stages an instruction uses.
// Kept standalone so the pipelined control logic can share it.
module seq_icode_class
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       need_mem_o,
  output logic       need_wb_o
);

  // Decode the stage requirements from the instruction code
  always_comb begin
    need_mem_o = 1'b0;
    need_wb_o  = 1'b0;
    case (icode_i)
      I_RRMOVQ, I_IRMOVQ, I_OPQ: need_wb_o = 1'b1;
      I_RMMOVQ:                  need_mem_o = 1'b1;
      I_MRMOVQ, I_CALL, I_RET,
      I_PUSHQ, I_POPQ: begin
        need_mem_o = 1'b1;
        need_wb_o  = 1'b1;
      end
      default: begin
        need_mem_o = 1'b0;
        need_wb_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle Y86-64 SEQ sequencer: walks each instruction through the
// stages it needs, handles the data-memory handshake with a timeout and
// parks in HALTED with the matching status code.
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [3:0]       icode_q,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  // Wait index of the last MEMORY cycle that may still receive an ack
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrl_state_t      state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [3:0]       icode_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             retire;
  logic             need_mem, need_wb;

  // Classify the instruction in flight (latched icode, not the fetch bus)
  seq_icode_class u_class (
    .icode_i    (icode_q),
    .need_mem_o (need_mem),
    .need_wb_o  (need_wb)
  );

  // Next-state, status and retire decision
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_error) begin
          state_d = ST_HALTED;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = ST_HALTED;
          stat_d  = STAT_INS;
        end else if (icode == I_HALT) begin
          state_d = ST_HALTED;
          stat_d  = STAT_HLT;
          retire  = 1'b1;
        end else begin
          icode_d = icode;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (need_mem) begin
          state_d = ST_MEMORY;
          wait_d  = 8'd0;
        end else if (need_wb) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_PCUPDATE;
        end
      end
      ST_MEMORY: begin
        if (mem_ack) begin
          if (dmem_error) begin
            state_d = ST_HALTED;
            stat_d  = STAT_ADR;
          end else begin
            state_d = need_wb ? ST_WRITEBACK : ST_PCUPDATE;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALTED;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WRITEBACK: state_d = ST_PCUPDATE;
      ST_PCUPDATE: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore stage enables decoded straight from the current state
  always_comb begin
    fetch_en     = (state_q == ST_FETCH);
    decode_en    = (state_q == ST_DECODE);
    execute_en   = (state_q == ST_EXECUTE);
    memory_en    = (state_q == ST_MEMORY);
    writeback_en = (state_q == ST_WRITEBACK);
    pc_en        = (state_q == ST_PCUPDATE);
    busy         = fetch_en | decode_en | execute_en | memory_en |
                   writeback_en | pc_en;
  end

  // Saturating counters: stick at all-ones rather than wrap
  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (busy && (cycle_q != '1)) cycle_d = cycle_q + CNT_W'(1);
    if (retire && (instr_q != '1)) instr_d = instr_q + CNT_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= I_NOP;
      wait_q  <= 8'd0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      wait_q  <= wait_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign stat        = stat_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller: a stage-level reference model
// predicts the enable sequence, latched icodes and final status/counters.
module tb_seq_stage_controller;

  localparam int CNT_W = 32;
  localparam int TO    = 15;

  localparam logic [5:0] E_F = 6'b100000;
  localparam logic [5:0] E_D = 6'b010000;
  localparam logic [5:0] E_E = 6'b001000;
  localparam logic [5:0] E_M = 6'b000100;
  localparam logic [5:0] E_W = 6'b000010;
  localparam logic [5:0] E_P = 6'b000001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       icode = 4'h0;
  logic             instr_valid = 1'b0;
  logic             imem_error = 1'b0;
  logic             mem_ack = 1'b0;
  logic             dmem_error = 1'b0;
  logic             fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
  logic [2:0]       stat;
  logic             busy;
  logic [3:0]       icode_q;
  logic [CNT_W-1:0] cycle_count, instr_count;

  typedef struct {
    logic [3:0] icode;
    bit         valid;
    bit         ierr;
    int         delay;   // MEMORY cycle carrying the ack; 0 = never ack
    bit         derr;
  } instr_t;

  instr_t     prog[$];
  logic [5:0] exp_q[$];
  logic [3:0] exp_ic[$];
  int         pc, cur, mem_cnt;
  int         exp_stat, exp_instr, exp_cycles;
  int         checks = 0;
  int         errors = 0;

  seq_stage_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .mem_ack(mem_ack), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .pc_en(pc_en),
    .stat(stat), .busy(busy), .icode_q(icode_q),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] en_vec();
    return {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en};
  endfunction

  // Environment: instruction memory on FETCH, data memory on MEMORY,
  // random noise on every input the controller should be ignoring.
  initial begin
    cur = 0;
    mem_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && fetch_en && pc < prog.size()) begin
        icode       = prog[pc].icode;
        instr_valid = prog[pc].valid;
        imem_error  = prog[pc].ierr;
        cur = pc;
        pc++;
      end else begin
        icode       = 4'($urandom);
        instr_valid = 1'($urandom);
        imem_error  = 1'($urandom);
      end
      if (rst_n && memory_en) begin
        mem_cnt++;
        if (prog[cur].delay != 0 && mem_cnt == prog[cur].delay) begin
          mem_ack    = 1'b1;
          dmem_error = prog[cur].derr;
        end else begin
          mem_ack    = 1'b0;
          dmem_error = 1'($urandom);
        end
      end else begin
        mem_cnt    = 0;
        mem_ack    = 1'($urandom);
        dmem_error = 1'($urandom);
      end
    end
  end

  // Monitor: every cycle with an enable pops one expected stage
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (en_vec() != 6'b0) begin
          check("busy_active", {63'b0, busy}, 64'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_enable actual=%b required=none", en_vec());
          end else begin
            e = exp_q.pop_front();
            check("stage_enable", {58'b0, en_vec()}, {58'b0, e});
          end
          if (decode_en) begin
            if (exp_ic.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_decode actual=%0h required=none", icode_q);
            end else begin
              check("icode_q", {60'b0, icode_q}, {60'b0, exp_ic.pop_front()});
            end
          end
        end else begin
          check("busy_idle", {63'b0, busy}, 64'd0);
        end
      end
    end
  end

  task automatic push_n(input logic [5:0] e, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  // Reference model: stages each instruction needs, from its class
  task automatic build_model();
    bit m, w;
    exp_q.delete();
    exp_ic.delete();
    exp_stat  = 1;
    exp_instr = 0;
    foreach (prog[i]) begin
      exp_q.push_back(E_F);
      if (prog[i].ierr)        begin exp_stat = 3; break; end
      if (!prog[i].valid)      begin exp_stat = 4; break; end
      if (prog[i].icode == 0)  begin exp_stat = 2; exp_instr++; break; end
      exp_ic.push_back(prog[i].icode);
      exp_q.push_back(E_D);
      exp_q.push_back(E_E);
      m = prog[i].icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      w = prog[i].icode inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
      if (m) begin
        if (prog[i].delay == 0 || prog[i].delay > TO) begin
          push_n(E_M, TO);
          exp_stat = 3;
          break;
        end
        push_n(E_M, prog[i].delay);
        if (prog[i].derr) begin exp_stat = 3; break; end
      end
      if (w) exp_q.push_back(E_W);
      exp_q.push_back(E_P);
      exp_instr++;
    end
    exp_cycles = exp_q.size();
  endtask

  task automatic add(input logic [3:0] ic, input int dly = 1, input bit derr = 0,
                     input bit valid = 1, input bit ierr = 0);
    instr_t t;
    t.icode = ic; t.valid = valid; t.ierr = ierr; t.delay = dly; t.derr = derr;
    prog.push_back(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input string tag);
    bit done;
    do_reset();
    build_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy) begin done = 1; break; end
      @(negedge clk);
      start = 1'($urandom);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=halted", tag);
    end
    check("stat", {61'b0, stat}, 64'(exp_stat));
    check("instr_count", 64'(instr_count), 64'(exp_instr));
    check("cycle_count", 64'(cycle_count), 64'(exp_cycles));
    check("stages_left", 64'(exp_q.size()), 64'd0);
    // HALTED must ignore start
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("halted_busy", {63'b0, busy}, 64'd0);
    end
    check("halted_stat", {61'b0, stat}, 64'(exp_stat));
    start = 1'b0;
    $display("TXN %s stat=%0d instr=%0d cycles=%0d", tag, stat, instr_count, cycle_count);
  endtask

  initial begin
    bit seen;
    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_en", {58'b0, en_vec()}, 64'd0);
    check("rst_stat", {61'b0, stat}, 64'd1);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_icode_q", {60'b0, icode_q}, 64'h1);
    check("rst_cycles", 64'(cycle_count), 64'd0);
    check("rst_instr", 64'(instr_count), 64'd0);
    $display("TXN reset stat=%0d", stat);

    prog.delete(); add(4'h3); add(4'h6); add(4'h0);
    run_prog("irmov_opq_halt");
    prog.delete(); add(4'h5, 3); add(4'h0);
    run_prog("mrmov_wait3");
    prog.delete(); add(4'h4, 1, 1);
    run_prog("rmmov_dmem_err");
    prog.delete(); add(4'hA, 0);
    run_prog("pushq_timeout");
    prog.delete(); add(4'hB, TO); add(4'h0);
    run_prog("popq_ack_last");
    prog.delete(); add(4'h1); add(4'h7); add(4'h2); add(4'h8); add(4'h9); add(4'h0);
    run_prog("mix");
    prog.delete(); add(4'h0, 1, 0, 0, 0);
    run_prog("invalid");
    prog.delete(); add(4'h0, 1, 0, 0, 1);
    run_prog("imem_err_and_invalid");

    for (int r = 0; r < 6; r++) begin
      prog.delete();
      for (int k = 0; k < 6; k++) begin
        int d;
        d = $urandom_range(1, 4);
        if ($urandom_range(0, 9) == 0) d = TO;
        if ($urandom_range(0, 19) == 0) d = 0;
        add(4'($urandom_range(1, 11)), d, ($urandom_range(0, 15) == 0));
      end
      add(4'h0);
      run_prog($sformatf("random%0d", r));
    end

    // Asynchronous reset during EXECUTE
    prog.delete(); add(4'h6); add(4'h0);
    do_reset();
    build_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (execute_en) begin seen = 1; break; end
      @(negedge clk);
    end
    check("saw_execute", {63'b0, seen}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", {58'b0, en_vec()}, 64'd0);
    check("arst_stat", {61'b0, stat}, 64'd1);
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_icode_q", {60'b0, icode_q}, 64'h1);
    check("arst_cycles", 64'(cycle_count), 64'd0);
    check("arst_instr", 64'(instr_count), 64'd0);
    exp_q.delete();
    exp_ic.delete();
    repeat (3) begin
      @(negedge clk);
      check("arst_hold_en", {58'b0, en_vec()}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_after_en", {58'b0, en_vec()}, 64'd0);
    $display("TXN async_reset stat=%0d instr=%0d cycles=%0d", stat, instr_count, cycle_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle sequencer for the Y86-64 SEQ datapath. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC-update, one stage per cycle. Stages an instruction does not need are skipped. It handles the data-memory handshake with a timeout and stops the processor with the correct Y86 status code on halt, invalid instruction or address error. The block sits above the fetch/decode/execute/memory units and drives their per-stage enables.

## Interface
Parameters:
- CNT_W, 32, width of the cycle and instruction counters
- MEM_TIMEOUT, 15, maximum MEMORY cycles waited for mem_ack (legal range 1..255)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled; begins execution from IDLE
- icode  in  4  instruction code from fetch; sampled at the end of FETCH
- instr_valid  in  1  fetch reports a legal icode; sampled in FETCH
- imem_error  in  1  instruction-memory address error; sampled in FETCH
- mem_ack  in  1  data memory completed the access
- dmem_error  in  1  data-memory address error; valid with mem_ack
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  out  1 each  stage enables, one-hot or all zero
- stat  out  3  status code: AOK=1, HLT=2, ADR=3, INS=4
- busy  out  1  high in FETCH..PCUPDATE
- icode_q  out  4  latched icode of the instruction in flight
- cycle_count  out  CNT_W  busy cycles, saturating
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED.
- Stage enables are Moore outputs: the enable is high exactly while the machine is in the matching state.
- Instruction classes by icode:
  - need_mem = icode in {4,5,8,9,A,B}
  - need_wb = icode in {2,3,5,6,8,9,A,B}
- IDLE: with start=1, go to FETCH next cycle. Otherwise stay.
- FETCH: the checks below apply in priority order.
  - imem_error=1: go to HALTED, stat=ADR.
  - Otherwise instr_valid=0: go to HALTED, stat=INS.
  - Otherwise icode=0 (halt): go to HALTED, stat=HLT, instr_count+1.
  - Otherwise: latch icode_q, go to DECODE.
- DECODE: go to EXECUTE.
- EXECUTE: next state is the first match of:
  - MEMORY if need_mem
  - WRITEBACK if need_wb
  - PCUPDATE otherwise
- MEMORY (memory_en acts as the request):
  - mem_ack=1 and dmem_error=1: go to HALTED, stat=ADR. No WB, no PC update, instruction not counted.
  - mem_ack=1 and dmem_error=0: go to WRITEBACK if need_wb, else PCUPDATE.
  - No ack after MEM_TIMEOUT MEMORY cycles: go to HALTED, stat=ADR.
  - The wait counter clears on MEMORY entry.
- WRITEBACK: go to PCUPDATE.
- PCUPDATE: instr_count+1, then go directly to FETCH. There is no return to IDLE.
- HALTED: absorbing state. All enables are 0 and stat holds its value. start is ignored; only rst_n exits.
- start is ignored outside IDLE. mem_ack and dmem_error are ignored outside MEMORY.
- Counters saturate at all-ones and never wrap.
- cycle_count increments on every cycle where busy=1.

## Timing
- Reset values: state=IDLE, all enables=0, stat=AOK(1), busy=0, icode_q=4'h1, both counters=0.
- Reset is asynchronous. Asserting rst_n mid-instruction forces reset values immediately. Nothing is retired and no further enables are issued.
- Cycles per instruction with a zero-wait ack (ack in the first MEMORY cycle), counted from FETCH to the next FETCH:
  - nop (1), jXX (7): 4
  - rrmovq/cmov (2), irmovq (3), opq (6): 5
  - rmmovq (4): 5
  - mrmovq (5), call (8), ret (9), pushq (A), popq (B): 6
  - Each additional memory wait cycle adds 1.
- An ack in MEMORY cycle k (1 ≤ k ≤ MEM_TIMEOUT) is accepted. With no ack, HALTED is entered after exactly MEM_TIMEOUT MEMORY cycles.
- All status and counter updates take effect on the clock edge that leaves the deciding state.

## Structure
- Shared package y86_pkg holds:
  - icode constants (HALT=0 … POPQ=B)
  - stat constants AOK/HLT/ADR/INS
  - state enum for this controller
- The sub-module seq_icode_class is a combinational icode→{need_mem, need_wb} decoder. The future PIPE control logic reuses it.

## Test plan
- Reset, start=1, program irmovq(3), opq(6), halt(0): enable sequence F,D,E,W,P,F,D,E,W,P,F → HALTED. stat=2, instr_count=3, cycle_count=11.
- mrmovq (5) with mem_ack delayed 3 cycles: MEMORY held 3 cycles with memory_en=1, then W, P. cycle_count=8.
- rmmovq (4) with mem_ack=1, dmem_error=1 in the first MEMORY cycle: HALTED, stat=3, pc_en never asserted, instr_count=0.
- pushq (A) with no ack and MEM_TIMEOUT=15: exactly 15 MEMORY cycles, then HALTED, stat=3.
- FETCH with instr_valid=0: HALTED, stat=4. A subsequent start pulse is ignored. With imem_error=1 and instr_valid=0 together: stat=3.
- rst_n pulsed low during EXECUTE of opq: outputs return to reset values asynchronously, and counters read 0.
